dmem_arbiter: RTL and testbench

Shares the single data memory (dmem) between the core load/store port and an external word-access port (debug/loader).
- The core has fixed priority.
- The external port is bounded by a starvation counter. On timeout the arbiter stalls the core for one cycle and serves the external request.
- Sits between the core (alu_res, rf_rs2, decoder dmem controls) and the dmem instance. core_stall feeds the pc/writeback enables.

---
 rtl/dmem_arbiter_if.sv | 22 ++
 rtl/dmem_arbiter.sv | 114 +++++++++++
 tb/tb_dmem_arbiter.sv | 388 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// External word-access port of the dmem arbiter (debug/loader side).
// The requester holds ext_req until ext_ack; ext_rdata stays valid until the next ack.
interface dmem_arbiter_if #(
  parameter int unsigned AddrWidth = 12
);
  logic                 ext_req;
  logic                 ext_we;
  logic [AddrWidth-1:0] ext_addr;
  logic [31:0]          ext_wdata;
  logic                 ext_ack;
  logic [31:0]          ext_rdata;

  modport master (
    output ext_req, ext_we, ext_addr, ext_wdata,
    input  ext_ack, ext_rdata
  );

  modport slave (
    input  ext_req, ext_we, ext_addr, ext_wdata,
    output ext_ack, ext_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares dmem between the core load/store port (fixed priority) and an external
// word port whose wait is bounded by MaxWait before a one-cycle forced core stall.
module dmem_arbiter #(
  parameter int unsigned AddrWidth = 12,
  parameter int unsigned MaxWait   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 core_req,
  input  logic                 core_write_enable,
  input  logic [1:0]           core_width,
  input  logic                 core_sign_extend,
  input  logic [AddrWidth-1:0] core_address,
  input  logic [31:0]          core_data_in,
  output logic                 core_stall,
  dmem_arbiter_if.slave        ext,
  output logic                 mem_write_enable,
  output logic [1:0]           mem_width,
  output logic                 mem_sign_extend,
  output logic [AddrWidth-1:0] mem_address,
  output logic [31:0]          mem_data_in,
  input  logic [31:0]          mem_data_out
);

  localparam int unsigned     CntWidth = $clog2(MaxWait + 1);
  localparam logic [CntWidth-1:0] CntLast = CntWidth'(MaxWait - 1);
  localparam logic [AddrWidth-1:0] WordMask = ~AddrWidth'(3);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK
  } state_e;

  state_e              state_q, state_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                grant_ext;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    grant_ext = (state_q != ACK) && ext.ext_req && (!core_req || (cnt_q == CntLast));

    // Read data is sampled from dmem in the grant cycle, ahead of the ack cycle.
    if (grant_ext && !ext.ext_we) begin
      rdata_d = mem_data_out;
    end

    unique case (state_q)
      IDLE: begin
        if (grant_ext) begin
          state_d = ACK;
        end else if (ext.ext_req) begin
          state_d = WAIT;
          cnt_d   = CntWidth'(1);
        end
      end
      WAIT: begin
        if (!ext.ext_req) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (grant_ext) begin
          state_d = ACK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntWidth'(1);
        end
      end
      ACK: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    if (grant_ext) begin
      mem_write_enable = ext.ext_we;
      mem_width        = 2'd2;
      mem_sign_extend  = 1'b0;
      mem_address      = ext.ext_addr & WordMask;
      mem_data_in      = ext.ext_wdata;
    end else begin
      mem_write_enable = core_write_enable;
      mem_width        = core_width;
      mem_sign_extend  = core_sign_extend;
      mem_address      = core_address;
      mem_data_in      = core_data_in;
    end
  end

  assign core_stall    = grant_ext & core_req;
  assign ext.ext_ack   = (state_q == ACK);
  assign ext.ext_rdata = rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: behavioural dmem model, expected external
// read data queued at request time and popped on each ext_ack.
module tb_dmem_arbiter;
  localparam int unsigned AW = 12;

  logic          clk;
  logic          reset;
  logic          core_req;
  logic          core_write_enable;
  logic [1:0]    core_width;
  logic          core_sign_extend;
  logic [AW-1:0] core_address;
  logic [31:0]   core_data_in;

  logic          core_stall, core_stall1;
  logic          mem_write_enable, mem_write_enable1;
  logic [1:0]    mem_width, mem_width1;
  logic          mem_sign_extend, mem_sign_extend1;
  logic [AW-1:0] mem_address, mem_address1;
  logic [31:0]   mem_data_in, mem_data_in1;
  logic [31:0]   mem_data_out;
  logic [31:0]   mem_data_out1;

  logic [31:0] mem [0:1023];
  logic [31:0] exp_q [$];
  logic [31:0] exp_v;
  int unsigned tests_run;
  int unsigned tests_failed;

  dmem_arbiter_if #(.AddrWidth(AW)) ext_if ();
  dmem_arbiter_if #(.AddrWidth(AW)) ext1_if ();

  dmem_arbiter #(.AddrWidth(AW), .MaxWait(4)) u_dut (
    .clk(clk), .reset(reset),
    .core_req(core_req), .core_write_enable(core_write_enable), .core_width(core_width),
    .core_sign_extend(core_sign_extend), .core_address(core_address), .core_data_in(core_data_in),
    .core_stall(core_stall), .ext(ext_if),
    .mem_write_enable(mem_write_enable), .mem_width(mem_width), .mem_sign_extend(mem_sign_extend),
    .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );

  dmem_arbiter #(.AddrWidth(AW), .MaxWait(1)) u_dut1 (
    .clk(clk), .reset(reset),
    .core_req(core_req), .core_write_enable(core_write_enable), .core_width(core_width),
    .core_sign_extend(core_sign_extend), .core_address(core_address), .core_data_in(core_data_in),
    .core_stall(core_stall1), .ext(ext1_if),
    .mem_write_enable(mem_write_enable1), .mem_width(mem_width1), .mem_sign_extend(mem_sign_extend1),
    .mem_address(mem_address1), .mem_data_in(mem_data_in1), .mem_data_out(mem_data_out1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_data_out  = mem[mem_address[11:2]];
  assign mem_data_out1 = 32'hCAFE_0000;

  // dmem model: preloaded on reset, byte/half/word stores on the clock edge.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
      mem[8]  <= 32'h0000_0055;
      mem[16] <= 32'hA5A5_0040;
    end else if (mem_write_enable) begin
      case (mem_width)
        2'd0:    mem[mem_address[11:2]][8*mem_address[1:0] +: 8] <= mem_data_in[7:0];
        2'd1:    mem[mem_address[11:2]][16*mem_address[1] +: 16] <= mem_data_in[15:0];
        default: mem[mem_address[11:2]] <= mem_data_in;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic core_idle();
    core_req          = 1'b0;
    core_write_enable = 1'b0;
    core_width        = 2'd2;
    core_sign_extend  = 1'b0;
    core_address      = 12'h0FC;
    core_data_in      = 32'h0;
  endtask

  task automatic ext_idle();
    ext_if.ext_req   = 1'b0;
    ext_if.ext_we    = 1'b0;
    ext_if.ext_addr  = '0;
    ext_if.ext_wdata = '0;
    ext1_if.ext_req   = 1'b0;
    ext1_if.ext_we    = 1'b0;
    ext1_if.ext_addr  = '0;
    ext1_if.ext_wdata = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    core_idle();
    ext_idle();
    tick();
    tick();
    reset = 1'b0;
    #1;
    tests_run++;
    if (core_stall !== 1'b0 || ext_if.ext_ack !== 1'b0 || ext_if.ext_rdata !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_state: stall=%b ack=%b rdata=%h, required 0 0 00000000",
               core_stall, ext_if.ext_ack, ext_if.ext_rdata);
    end
    tests_run++;
    if (mem_address !== 12'h0FC || mem_width !== 2'd2) begin
      tests_failed++;
      $display("FAIL reset_passthru: mem_address=%h width=%0d, required 0fc 2", mem_address, mem_width);
    end
  endtask

  task automatic test_ext_write();
    tick();
    ext_if.ext_req   = 1'b1;
    ext_if.ext_we    = 1'b1;
    ext_if.ext_addr  = 12'h013;
    ext_if.ext_wdata = 32'hDEAD_BEEF;
    exp_q.push_back(32'h0);
    #1;
    tests_run++;
    if (mem_address !== 12'h010 || mem_write_enable !== 1'b1 || mem_width !== 2'd2 ||
        mem_data_in !== 32'hDEAD_BEEF || core_stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL wr_grant: addr=%h we=%b width=%0d wdata=%h stall=%b, required 010 1 2 deadbeef 0",
               mem_address, mem_write_enable, mem_width, mem_data_in, core_stall);
    end
    tick();
    ext_idle();
    tests_run++;
    if (ext_if.ext_ack !== 1'b1) begin
      tests_failed++;
      $display("FAIL wr_ack: ack=%b, required 1", ext_if.ext_ack);
    end else begin
      exp_v = exp_q.pop_front();
      tests_run++;
      if (ext_if.ext_rdata !== exp_v) begin
        tests_failed++;
        $display("FAIL wr_rdata_held: rdata=%h, required %h", ext_if.ext_rdata, exp_v);
      end
    end
    tests_run++;
    if (mem[4] !== 32'hDEAD_BEEF || core_stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL wr_mem: word=%h stall=%b, required deadbeef 0", mem[4], core_stall);
    end
  endtask

  task automatic test_ext_read();
    tick();
    ext_if.ext_req  = 1'b1;
    ext_if.ext_we   = 1'b0;
    ext_if.ext_addr = 12'h010;
    exp_q.push_back(32'hDEAD_BEEF);
    tick();
    ext_idle();
    tests_run++;
    if (ext_if.ext_ack !== 1'b1) begin
      tests_failed++;
      $display("FAIL rd_ack: ack=%b, required 1", ext_if.ext_ack);
    end else begin
      exp_v = exp_q.pop_front();
      tests_run++;
      if (ext_if.ext_rdata !== exp_v) begin
        tests_failed++;
        $display("FAIL rd_data: rdata=%h, required %h", ext_if.ext_rdata, exp_v);
      end
    end
    tick();
    tick();
    tests_run++;
    if (ext_if.ext_ack !== 1'b0 || ext_if.ext_rdata !== 32'hDEAD_BEEF) begin
      tests_failed++;
      $display("FAIL rd_hold: ack=%b rdata=%h, required 0 deadbeef", ext_if.ext_ack, ext_if.ext_rdata);
    end
  endtask

  task automatic test_contention();
    tick();
    core_req        = 1'b1;
    core_address    = 12'h100;
    ext_if.ext_req  = 1'b1;
    ext_if.ext_we   = 1'b0;
    ext_if.ext_addr = 12'h041;
    exp_q.push_back(32'hA5A5_0040);
    for (int c = 0; c < 3; c++) begin
      if (c != 0) tick();
      #1;
      tests_run++;
      if (core_stall !== 1'b0 || mem_address !== 12'h100 || ext_if.ext_ack !== 1'b0) begin
        tests_failed++;
        $display("FAIL cont_core_owns c%0d: stall=%b addr=%h ack=%b, required 0 100 0",
                 c, core_stall, mem_address, ext_if.ext_ack);
      end
    end
    tick();
    core_write_enable = 1'b1;
    core_address      = 12'h020;
    core_data_in      = 32'h0000_0011;
    #1;
    tests_run++;
    if (core_stall !== 1'b1 || mem_address !== 12'h040 || mem_write_enable !== 1'b0) begin
      tests_failed++;
      $display("FAIL cont_forced: stall=%b addr=%h we=%b, required 1 040 0",
               core_stall, mem_address, mem_write_enable);
    end
    tick();
    ext_if.ext_req = 1'b0;
    #1;
    tests_run++;
    if (ext_if.ext_ack !== 1'b1 || core_stall !== 1'b0 || mem_address !== 12'h020 ||
        mem_write_enable !== 1'b1 || mem[8] !== 32'h0000_0055) begin
      tests_failed++;
      $display("FAIL cont_ack_cycle: ack=%b stall=%b addr=%h we=%b word=%h, required 1 0 020 1 00000055",
               ext_if.ext_ack, core_stall, mem_address, mem_write_enable, mem[8]);
    end
    if (ext_if.ext_ack === 1'b1) begin
      exp_v = exp_q.pop_front();
      tests_run++;
      if (ext_if.ext_rdata !== exp_v) begin
        tests_failed++;
        $display("FAIL cont_rdata: rdata=%h, required %h", ext_if.ext_rdata, exp_v);
      end
    end
    tick();
    core_idle();
    tests_run++;
    if (mem[8] !== 32'h0000_0011) begin
      tests_failed++;
      $display("FAIL cont_core_store: word=%h, required 00000011", mem[8]);
    end
  endtask

  task automatic test_back_to_back();
    tick();
    ext_if.ext_req  = 1'b1;
    ext_if.ext_we   = 1'b0;
    ext_if.ext_addr = 12'h010;
    exp_q.push_back(32'hDEAD_BEEF);
    exp_q.push_back(32'hDEAD_BEEF);
    for (int c = 0; c < 4; c++) begin
      if (c != 0) tick();
      #1;
      tests_run++;
      if (ext_if.ext_ack !== c[0] || mem_address !== ((c[0] == 1'b1) ? 12'h0FC : 12'h010)) begin
        tests_failed++;
        $display("FAIL b2b c%0d: ack=%b addr=%h, required %b %h", c, ext_if.ext_ack, mem_address,
                 c[0], (c[0] == 1'b1) ? 12'h0FC : 12'h010);
      end
      if (ext_if.ext_ack === 1'b1 && exp_q.size() != 0) begin
        exp_v = exp_q.pop_front();
        tests_run++;
        if (ext_if.ext_rdata !== exp_v) begin
          tests_failed++;
          $display("FAIL b2b_rdata c%0d: rdata=%h, required %h", c, ext_if.ext_rdata, exp_v);
        end
      end
    end
    ext_idle();
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL b2b_acks: %0d expected acks missing, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_drop_in_wait();
    tick();
    core_req       = 1'b1;
    ext_if.ext_req = 1'b1;
    tick();
    tick();
    ext_if.ext_req = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      tests_run++;
      if (ext_if.ext_ack !== 1'b0 || core_stall !== 1'b0) begin
        tests_failed++;
        $display("FAIL drop_no_ack c%0d: ack=%b stall=%b, required 0 0", c, ext_if.ext_ack, core_stall);
      end
    end
    core_idle();
  endtask

  task automatic test_reset_in_wait();
    tick();
    core_req        = 1'b1;
    ext_if.ext_req  = 1'b1;
    ext_if.ext_we   = 1'b0;
    ext_if.ext_addr = 12'h040;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    tests_run++;
    if (ext_if.ext_ack !== 1'b0 || ext_if.ext_rdata !== 32'h0 || core_stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_wait_state: ack=%b rdata=%h stall=%b, required 0 00000000 0",
               ext_if.ext_ack, ext_if.ext_rdata, core_stall);
    end
    exp_q.push_back(32'hA5A5_0040);
    // Counter must restart from zero: three more contended cycles before the forced grant.
    for (int c = 1; c < 4; c++) begin
      tick();
      tests_run++;
      if (core_stall !== (c == 3) || ext_if.ext_ack !== 1'b0) begin
        tests_failed++;
        $display("FAIL rst_wait_restart c%0d: stall=%b ack=%b, required %b 0", c, core_stall,
                 ext_if.ext_ack, (c == 3));
      end
    end
    tick();
    ext_if.ext_req = 1'b0;
    tests_run++;
    if (ext_if.ext_ack !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_wait_ack: ack=%b, required 1", ext_if.ext_ack);
      exp_q.delete();
    end else begin
      exp_v = exp_q.pop_front();
      tests_run++;
      if (ext_if.ext_rdata !== exp_v) begin
        tests_failed++;
        $display("FAIL rst_wait_rdata: rdata=%h, required %h", ext_if.ext_rdata, exp_v);
      end
    end
    core_idle();
  endtask

  task automatic test_maxwait1();
    tick();
    core_req         = 1'b1;
    core_address     = 12'h200;
    ext1_if.ext_req  = 1'b1;
    ext1_if.ext_we   = 1'b0;
    ext1_if.ext_addr = 12'h087;
    exp_q.push_back(32'hCAFE_0000);
    #1;
    tests_run++;
    if (core_stall1 !== 1'b1 || mem_address1 !== 12'h084 || mem_width1 !== 2'd2) begin
      tests_failed++;
      $display("FAIL mw1_forced: stall=%b addr=%h width=%0d, required 1 084 2",
               core_stall1, mem_address1, mem_width1);
    end
    tick();
    ext1_if.ext_req = 1'b0;
    tests_run++;
    if (ext1_if.ext_ack !== 1'b1 || core_stall1 !== 1'b0 || mem_address1 !== 12'h200) begin
      tests_failed++;
      $display("FAIL mw1_ack: ack=%b stall=%b addr=%h, required 1 0 200",
               ext1_if.ext_ack, core_stall1, mem_address1);
      exp_q.delete();
    end else begin
      exp_v = exp_q.pop_front();
      tests_run++;
      if (ext1_if.ext_rdata !== exp_v) begin
        tests_failed++;
        $display("FAIL mw1_rdata: rdata=%h, required %h", ext1_if.ext_rdata, exp_v);
      end
    end
    core_idle();
    tick();
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_ext_write();
    test_ext_read();
    test_contention();
    test_back_to_back();
    test_drop_in_wait();
    test_reset_in_wait();
    test_maxwait1();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
